// File: rtl/mux_rr_arbiter_if.sv
// Request/data/grant bundle between the requesters, the arbiter and the consumer of z.
interface mux_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] in;
   logic [1:0] s;
   logic [3:0] gnt;
   logic       z;
   logic       z_vld;
   logic       busy;

   modport master (output req, in, input s, gnt, z, z_vld, busy);
   modport slave  (input req, in, output s, gnt, z, z_vld, busy);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the 4:1 single-bit mux; grant lasts at most MAX_HOLD samples, then one PARK cycle.
// All outputs registered; no preemption, the owner keeps the grant until its req drops or the hold limit.
module mux_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CW       = 8
) (
   input logic             clk,
   input logic             rst_n,
   mux_rr_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GRANT, PARK} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    s_nxt;
   logic [3:0]    gnt_nxt;
   logic          z_nxt, z_vld_nxt, busy_nxt;
   logic          found;
   logic [1:0]    win, idx;

   // Search starts just after the last owner, so it always ends up with lowest priority.
   always_comb begin
      found = 1'b0;
      win   = bus.s;
      idx   = bus.s;
      for (int k = 1; k <= 4; k++) begin
         idx = bus.s + 2'(k);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      s_nxt     = bus.s;
      gnt_nxt   = bus.gnt;
      z_nxt     = bus.z;
      z_vld_nxt = 1'b0;
      case (state)
         GRANT: begin
            if (bus.req[bus.s]) begin
               z_nxt     = bus.in[bus.s];
               z_vld_nxt = 1'b1;
               if (cnt == CW'(MAX_HOLD - 1)) begin
                  state_nxt = PARK;
                  gnt_nxt   = 4'b0000;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end else begin
               state_nxt = PARK;
               gnt_nxt   = 4'b0000;
            end
         end
         default: begin
            if (found) begin
               state_nxt = GRANT;
               s_nxt     = win;
               gnt_nxt   = 4'b0001 << win;
               cnt_nxt   = '0;
            end else begin
               state_nxt = IDLE;
               gnt_nxt   = 4'b0000;
            end
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bus.s     <= 2'd3;
         bus.gnt   <= 4'b0000;
         bus.z     <= 1'b0;
         bus.z_vld <= 1'b0;
         bus.busy  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bus.s     <= s_nxt;
         bus.gnt   <= gnt_nxt;
         bus.z     <= z_nxt;
         bus.z_vld <= z_vld_nxt;
         bus.busy  <= busy_nxt;
      end
   end
endmodule
